// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/LSU memory arbiter.
// Holds the owner enum, arbiter FSM states, owner FIFO entry type and
// the default outstanding-depth / starvation limits.
package mem_arbiter_pkg;

    localparam int unsigned MAX_OUT_DEF    = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CNT_W          = 3;   // holds 0..4 outstanding
    localparam int unsigned STARVE_W       = 4;

    typedef enum logic {
        OWN_FET = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_GNT = 1'b1
    } state_e;

    typedef struct packed {
        owner_e owner;
        logic   drop;
    } fifo_entry_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner tracking FIFO for accepted bus transactions.
// Ports: clk/rst_n (async active-low), push + push_owner on acceptance,
// pop on bus response (ignored when empty), flush marks every fetch entry
// (including one pushed in the same cycle) as dropped; head/count/empty out.
module arb_owner_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  owner_e            push_owner,
    input  logic              pop,
    input  logic              flush,
    output fifo_entry_t       head,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (cnt == '0);
    assign do_pop = pop && !empty;   // a stray response on an empty FIFO is ignored
    assign head   = entries[rd_ptr];
    assign count  = cnt;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (entries[i].owner == OWN_FET) begin
                        entries[i].drop <= 1'b1;
                    end
                end
            end
            if (push) begin
                entries[wr_ptr] <= '{owner: push_owner,
                                     drop:  flush && (push_owner == OWN_FET)};
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch, load/store unit) arbiter onto one
// pipelined in-order memory bus.
// Ports: clk_i, rst_n_i (async active-low); fet_* fetch read port with
// flush; lsu_* load/store port; mem_* shared bus request/response.
// Grants and response strobes are same-cycle combinational; all outputs
// are held at 0 while reset is asserted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT    = MAX_OUT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fet_req_i,
    input  logic [31:0] fet_addr_i,
    input  logic        fet_flush_i,
    output logic        fet_gnt_o,
    output logic        fet_rvalid_o,
    output logic [31:0] fet_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    state_e              state;
    owner_e              owner_q;
    owner_e              owner_sel;
    owner_e              owner;
    logic [STARVE_W-1:0] starve;
    logic [CNT_W-1:0]    out_cnt;
    logic                fifo_empty;
    fifo_entry_t         head;
    logic                want;
    logic                accept;
    logic                rsp_valid;

    // Idle arbitration: LSU priority unless fetch has been starved long enough
    always_comb begin
        owner_sel = OWN_LSU;
        if (fet_req_i && (!lsu_req_i || (starve == STARVE_W'(STARVE_MAX)))) begin
            owner_sel = OWN_FET;
        end
    end

    assign owner     = (state == ST_WAIT_GNT) ? owner_q : owner_sel;
    assign want      = (state == ST_WAIT_GNT) || fet_req_i || lsu_req_i;
    // Full check uses current occupancy; a same-cycle pop does not free a slot
    assign mem_req_o = rst_n_i && want && (out_cnt != CNT_W'(MAX_OUT));
    assign accept    = mem_req_o && mem_gnt_i;

    assign fet_gnt_o = accept && (owner == OWN_FET);
    assign lsu_gnt_o = accept && (owner == OWN_LSU);

    // Bus payload mux; fetch is always a full-word read
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            if (owner == OWN_FET) begin
                mem_be_o   = 4'hF;
                mem_addr_o = fet_addr_i;
            end else begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end
        end
    end

    // Response routing; a flush in the pop cycle also discards the fetch response
    assign rsp_valid    = mem_rvalid_i && !fifo_empty;
    assign fet_rvalid_o = rsp_valid && (head.owner == OWN_FET) && !head.drop && !fet_flush_i;
    assign lsu_rvalid_o = rsp_valid && (head.owner == OWN_LSU);
    assign fet_rdata_o  = fet_rvalid_o ? mem_rdata_i : 32'h0;
    assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : 32'h0;

    // Grant-wait FSM, latched owner and fetch starvation counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            owner_q <= OWN_FET;
            starve  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state   <= ST_WAIT_GNT;
                        owner_q <= owner_sel;
                    end
                end
                ST_WAIT_GNT: begin
                    if (mem_gnt_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (!fet_req_i || (accept && (owner == OWN_FET))) begin
                starve <= '0;
            end else if (accept && (starve != STARVE_W'(STARVE_MAX))) begin
                starve <= starve + STARVE_W'(1);
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .push       (accept),
        .push_owner (owner),
        .pop        (mem_rvalid_i),
        .flush      (fet_flush_i),
        .head       (head),
        .count      (out_cnt),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, starvation, grant wait,
// flush dropping, outstanding limit and asynchronous reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fet_req;
    logic [31:0] fet_addr;
    logic        fet_flush;
    logic        fet_gnt;
    logic        fet_rvalid;
    logic [31:0] fet_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .MAX_OUT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .fet_req_i    (fet_req),
        .fet_addr_i   (fet_addr),
        .fet_flush_i  (fet_flush),
        .fet_gnt_o    (fet_gnt),
        .fet_rvalid_o (fet_rvalid),
        .fet_rdata_o  (fet_rdata),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_be_i     (lsu_be),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fet_req    = 1'b0;
        fet_addr   = 32'h0;
        fet_flush  = 1'b0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_be     = 4'h0;
        lsu_addr   = 32'h0;
        lsu_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        logic exp_lsu;
        // Reset: outputs held low even with active requests on the inputs
        rst_n = 1'b0;
        clear_inputs();
        fet_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h44; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        #2;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_lsu_gnt", 32'(lsu_gnt), 32'h0);
        check("rst_fet_gnt", 32'(fet_gnt), 32'h0);
        check("rst_rvalid", {30'h0, fet_rvalid, lsu_rvalid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_inputs();
        tick();

        // Both request with counter 0: LSU wins same cycle
        fet_req = 1'b1; fet_addr = 32'h80; lsu_req = 1'b1; lsu_addr = 32'h40; mem_gnt = 1'b1;
        #1;
        check("both_lsu_gnt", 32'(lsu_gnt), 32'h1);
        check("both_fet_gnt", 32'(fet_gnt), 32'h0);
        check("both_addr", mem_addr, 32'h40);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        check("both_lsu_rvalid", 32'(lsu_rvalid), 32'h1);
        check("both_lsu_rdata", lsu_rdata, 32'h1234_5678);
        check("both_fet_rdata", fet_rdata, 32'h0);
        tick();
        clear_inputs();
        tick();

        // Starvation: four LSU grants, fifth to fetch, sixth back to LSU
        fet_req = 1'b1; fet_addr = 32'h100; lsu_req = 1'b1; lsu_addr = 32'h200;
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            mem_rdata = 32'hA000_0000 + 32'(k);
            #1;
            exp_lsu = (k != 5);
            check($sformatf("starve_lsu_gnt_%0d", k), 32'(lsu_gnt), 32'(exp_lsu));
            check($sformatf("starve_fet_gnt_%0d", k), 32'(fet_gnt), 32'(!exp_lsu));
            // response k returns accept k-1; nothing outstanding in cycle 1
            check($sformatf("starve_fet_rv_%0d", k), 32'(fet_rvalid), 32'(k == 6));
            check($sformatf("starve_lsu_rv_%0d", k), 32'(lsu_rvalid), 32'(k >= 2 && k != 6));
            tick();
        end
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_0006;
        #1;
        check("starve_drain_lsu_rv", 32'(lsu_rvalid), 32'h1);
        check("starve_drain_rdata", lsu_rdata, 32'h5555_0006);
        tick();
        clear_inputs();
        tick();

        // Grant wait: fetch address held while LSU request appears
        fet_req = 1'b1; fet_addr = 32'h100;
        #1;
        check("wait_req", 32'(mem_req), 32'h1);
        check("wait_addr0", mem_addr, 32'h100);
        tick();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'h3; lsu_addr = 32'h300;
        for (int k = 1; k <= 2; k++) begin
            #1;
            check($sformatf("wait_addr%0d", k), mem_addr, 32'h100);
            check($sformatf("wait_we%0d", k), 32'(mem_we), 32'h0);
            check($sformatf("wait_lsu_gnt%0d", k), 32'(lsu_gnt), 32'h0);
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        check("wait_fet_gnt", 32'(fet_gnt), 32'h1);
        check("wait_be", 32'(mem_be), 32'hF);
        check("wait_addr_gnt", mem_addr, 32'h100);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0100;
        #1;
        check("wait_fet_rvalid", 32'(fet_rvalid), 32'h1);
        check("wait_fet_rdata", fet_rdata, 32'hCAFE_0100);
        tick();
        clear_inputs();
        tick();

        // Flush after two accepted fetches: both responses dropped
        fet_req = 1'b1; fet_addr = 32'h300; mem_gnt = 1'b1;
        tick();
        fet_addr = 32'h304;
        tick();
        clear_inputs();
        fet_flush = 1'b1;
        tick();
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("flush_fet_rv%0d", k), 32'(fet_rvalid), 32'h0);
            check($sformatf("flush_fet_rdata%0d", k), fet_rdata, 32'h0);
            tick();
        end
        clear_inputs();
        // FIFO must be empty: a fresh LSU response is routed to the LSU
        lsu_req = 1'b1; lsu_addr = 32'h500; mem_gnt = 1'b1;
        tick();
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0500;
        #1;
        check("flush_empty_lsu_rv", 32'(lsu_rvalid), 32'h1);
        tick();
        clear_inputs();

        // Flush in the grant cycle of a waiting fetch: pushed already dropped
        fet_req = 1'b1; fet_addr = 32'h600;
        tick();
        fet_flush = 1'b1; mem_gnt = 1'b1;
        #1;
        check("flushgnt_req", 32'(mem_req), 32'h1);
        check("flushgnt_fet_gnt", 32'(fet_gnt), 32'h1);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1;
        #1;
        check("flushgnt_fet_rv", 32'(fet_rvalid), 32'h0);
        tick();
        clear_inputs();
        tick();

        // Outstanding limit: full blocks request even with a same-cycle pop
        lsu_req = 1'b1; lsu_addr = 32'h700; mem_gnt = 1'b1;
        tick();
        tick();
        mem_rvalid = 1'b1;
        #1;
        check("full_req", 32'(mem_req), 32'h0);
        check("full_lsu_gnt", 32'(lsu_gnt), 32'h0);
        check("full_lsu_rv", 32'(lsu_rvalid), 32'h1);
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("full_req_next", 32'(mem_req), 32'h1);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1;
        tick();
        tick();
        clear_inputs();
        tick();

        // Asynchronous reset in grant wait, then a clean LSU write
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h900; lsu_wdata = 32'h1111_1111;
        tick();
        #2;
        rst_n = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_lsu_gnt", 32'(lsu_gnt), 32'h0);
        check("arst_lsu_rv", 32'(lsu_rvalid), 32'h0);
        check("arst_wdata", mem_wdata, 32'h0);
        tick();
        rst_n = 1'b1;
        clear_inputs();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h20; lsu_wdata = 32'hDEAD_BEEF;
        mem_gnt = 1'b1;
        #1;
        check("post_lsu_gnt", 32'(lsu_gnt), 32'h1);
        check("post_we", 32'(mem_we), 32'h1);
        check("post_addr", mem_addr, 32'h20);
        check("post_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        mem_rvalid = 1'b1;
        #1;
        check("post_lsu_rv", 32'(lsu_rvalid), 32'h1);
        tick();
        #1;
        check("post_lsu_rv_once", 32'(lsu_rvalid), 32'h0);
        tick();
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 2: maximum outstanding bus transactions, range 1..4.
REQ-002 Parameter STARVE_MAX, default 4: consecutive LSU grants allowed while fetch waits; range 1..15.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 fet_req_i  in  1 / fet_addr_i  in  32  fetch read request and word address.
REQ-006 fet_flush_i  in  1  pipeline redirect; discards in-flight fetch responses.
REQ-007 fet_gnt_o  out  1 / fet_rvalid_o  out  1 / fet_rdata_o  out  32  fetch grant, response strobe, read data.
REQ-008 lsu_req_i  in  1 / lsu_we_i  in  1 / lsu_be_i  in  4 / lsu_addr_i  in  32 / lsu_wdata_i  in  32  load/store request.
REQ-009 lsu_gnt_o  out  1 / lsu_rvalid_o  out  1 / lsu_rdata_o  out  32  LSU grant, response strobe, read data.
REQ-010 mem_req_o  out  1 / mem_we_o  out  1 / mem_be_o  out  4 / mem_addr_o  out  32 / mem_wdata_o  out  32  shared bus request.
REQ-011 mem_gnt_i  in  1 / mem_rvalid_i  in  1 / mem_rdata_i  in  32  bus grant, in-order response strobe, read data.

Function
REQ-012 Bus handshake: transaction accepted in any cycle with mem_req_o && mem_gnt_i; exactly one mem_rvalid_i per accepted transaction (writes included), returned in order, earliest the cycle after acceptance.
REQ-013 FSM states IDLE and WAIT_GNT; IDLE -> WAIT_GNT when mem_req_o asserted and mem_gnt_i low; WAIT_GNT -> IDLE on mem_gnt_i.
REQ-014 In IDLE, owner selection combinational: LSU wins over fetch unless starve counter == STARVE_MAX and fet_req_i high, then fetch wins.
REQ-015 In WAIT_GNT, owner latched; mem_* outputs carry the latched owner's inputs; requester must hold request stable until its grant.
REQ-016 Fetch transactions drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-017 fet_gnt_o/lsu_gnt_o = mem_gnt_i && mem_req_o && (owner matches), same cycle, no registering.
REQ-018 mem_req_o forced low while outstanding count == MAX_OUT, even if mem_rvalid_i pops in the same cycle.
REQ-019 Owner FIFO (depth MAX_OUT) pushes {owner, drop=0} on acceptance; pops on mem_rvalid_i; simultaneous push and pop leave count unchanged.
REQ-020 Response routing: mem_rvalid_i forwarded to head owner's rvalid, rdata = mem_rdata_i, same cycle; non-owner rdata outputs driven 0.
REQ-021 fet_flush_i sets drop on every FIFO entry whose owner is fetch, including an entry pushed that same cycle; dropped responses pop with fet_rvalid_o held 0.
REQ-022 fet_flush_i during WAIT_GNT with fetch owner does not withdraw mem_req_o; the transaction, once accepted, is pushed with drop=1.
REQ-023 Starve counter (4 bits): increments on each LSU acceptance while fet_req_i high, saturating at STARVE_MAX; clears on fetch acceptance or when fet_req_i low.
REQ-024 mem_rvalid_i with empty FIFO is a protocol error: ignored, no output strobe, counters unchanged.

Reset
REQ-025 On rst_n_i low: state IDLE, FIFO empty, drop bits 0, starve counter 0, all grant/rvalid outputs 0, mem_req_o 0, data outputs 0.
REQ-026 Reset mid-transaction abandons all outstanding responses; first accepted request after release is decided by REQ-014 with counter 0.

Structure
REQ-027 Shared package holds owner enum (OWN_FET, OWN_LSU), MAX_OUT/STARVE_MAX defaults and the FIFO entry typedef {owner, drop}.
REQ-028 Owner FIFO is one sub-module, arb_owner_fifo, with push/pop/flush-mark ports; remainder is flat in mem_arbiter.

Verification
REQ-029 Both request, counter 0, mem_gnt_i=1 -> lsu_gnt_o=1, fet_gnt_o=0, same cycle.
REQ-030 LSU requests continuously with fetch pending, STARVE_MAX=4 -> four LSU acceptances, fifth acceptance to fetch, counter then 0.
REQ-031 Fetch at 0x100, mem_gnt_i held low 3 cycles while lsu_req_i rises -> mem_addr_o stays 0x100 until granted.
REQ-032 Two fetch reads accepted, fet_flush_i pulsed, two mem_rvalid_i -> fet_rvalid_o never asserted, FIFO empty afterwards.
REQ-033 MAX_OUT=2, two accepted, third request with mem_rvalid_i in same cycle -> mem_req_o 0 that cycle, 1 next cycle.
REQ-034 rst_n_i low mid-WAIT_GNT -> all outputs 0 asynchronously; after release, new LSU write 0x20/0xDEADBEEF completes with one lsu_rvalid_o.
